// File: rtl/uart_defs.sv
// Shared UART receive definitions: state encodings and default frame timing.
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_BAUD_DIV  = 434;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/rx_bit_sampler_if.sv
// Receive-side signal bundle between the start-edge detector / line and the bit sampler.
interface rx_bit_sampler_if
  import uart_defs::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);

  logic                 Rx_Pin_In;
  logic                 H2L_Sig;
  logic                 Rx_En;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Rx_Done_Sig;
  logic                 Frame_Err;

  modport master (
    output Rx_Pin_In, H2L_Sig, Rx_En,
    input  Rx_Data, Rx_Done_Sig, Frame_Err
  );

  modport slave (
    input  Rx_Pin_In, H2L_Sig, Rx_En,
    output Rx_Data, Rx_Done_Sig, Frame_Err
  );

endinterface

// File: rtl/rx_bit_sampler_baud_counter.sv
// Bit-period counter: flags the half-bit and full-bit points and restarts after a full bit.
module rx_baud_counter
  import uart_defs::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = $clog2(BAUD_DIV);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t HALF_CNT = cnt_t'(BAUD_DIV / 2 - 1);
  localparam cnt_t FULL_CNT = cnt_t'(BAUD_DIV - 1);

  cnt_t cnt;

  assign half_tick = (cnt == HALF_CNT);
  assign full_tick = (cnt == FULL_CNT);

  // Wrap to zero at terminal count so the count never runs past BAUD_DIV-1.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= full_tick ? '0 : cnt + cnt_t'(1);
    end
  end

endmodule

// File: rtl/rx_bit_sampler.sv
// UART receive control: times bits from the start edge, samples mid-bit, checks the stop bit.
module rx_bit_sampler
  import uart_defs::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic             CLK,
  input  logic             RSTn,
  rx_bit_sampler_if.slave  rx
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  rx_state_t            state, next_state;
  logic                 rx_meta, rx_s;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 done_q, err_q;
  logic                 cnt_clear, cnt_en, half_tick, full_tick;
  logic                 shift_en, load_word, flag_err;

  rx_baud_counter #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .clear     (cnt_clear),
    .enable    (cnt_en),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // The serial line is asynchronous; sync flops idle high to match the line.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx.Rx_Pin_In;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    shift_en   = 1'b0;
    load_word  = 1'b0;
    flag_err   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (rx.Rx_En && rx.H2L_Sig) next_state = START;
      end
      START: begin
        cnt_en = 1'b1;
        if (half_tick) begin
          cnt_clear  = 1'b1;
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_en = 1'b1;
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_IDX) next_state = STOP;
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        if (full_tick) begin
          next_state = IDLE;
          load_word  = rx_s;
          flag_err   = !rx_s;
        end
      end
      default: next_state = IDLE;
    endcase
    // Dropping the enable abandons the frame silently, overriding any sample this cycle.
    if (state != IDLE && !rx.Rx_En) begin
      next_state = IDLE;
      cnt_clear  = 1'b1;
      cnt_en     = 1'b0;
      shift_en   = 1'b0;
      load_word  = 1'b0;
      flag_err   = 1'b0;
    end
  end

  // Line order is LSB first, so each new bit enters at the MSB and moves down.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= load_word;
      err_q  <= flag_err;
      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (shift_en && bit_idx != LAST_IDX) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (load_word) rx_data_q <= shift_reg;
    end
  end

  assign rx.Rx_Data     = rx_data_q;
  assign rx.Rx_Done_Sig = done_q;
  assign rx.Frame_Err   = err_q;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Self-checking bench for rx_bit_sampler: drives whole UART frames and compares against a frame-level model.
module tb_rx_bit_sampler;

  localparam int BAUD  = 16;
  localparam int DBITS = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rx_bit_sampler_if #(.DATA_BITS(DBITS)) bus ();

  rx_bit_sampler #(.BAUD_DIV(BAUD), .DATA_BITS(DBITS)) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .rx   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] done_q[$];
  int         done_cyc[$];
  int         err_cnt  = 0;
  int         both_cnt = 0;
  logic [7:0] exp_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records every done word with its cycle, and every error pulse.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.Rx_Done_Sig) begin
        done_q.push_back(bus.Rx_Data);
        done_cyc.push_back(cyc);
      end
      if (bus.Frame_Err) err_cnt++;
      if (bus.Rx_Done_Sig && bus.Frame_Err) both_cnt++;
    end
  end

  task automatic clear_mon();
    done_q.delete();
    done_cyc.delete();
    err_cnt  = 0;
    both_cnt = 0;
  endtask

  // All line tasks start and end aligned just after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      #1;
      bus.Rx_Pin_In = 1'b1;
      bus.H2L_Sig   = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int start_cyc);
    logic [9:0] frame;
    frame = {stop_bit, d, 1'b0};
    start_cyc = cyc;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < BAUD; k++) begin
        #1;
        bus.Rx_Pin_In = frame[b];
        bus.H2L_Sig   = (b == 0 && k == 0);
        if (b == 0 && k == 0) start_cyc = cyc;
        @(posedge clk);
      end
    end
  endtask

  task automatic test_reset();
    bus.Rx_Pin_In = 1'b1;
    bus.H2L_Sig   = 1'b0;
    bus.Rx_En     = 1'b1;
    rstn          = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (bus.Rx_Data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h expected=00", bus.Rx_Data);
    end
    checks++;
    if (bus.Rx_Done_Sig !== 1'b0 || bus.Frame_Err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes got=%b%b expected=00", bus.Rx_Done_Sig, bus.Frame_Err);
    end
    rstn = 1'b1;
    @(posedge clk);
    idle(10);
    checks++;
    if (bus.Rx_Done_Sig !== 1'b0 || bus.Frame_Err !== 1'b0 || bus.Rx_Data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL post_reset_idle got=%b%b/%h expected=00/00",
               bus.Rx_Done_Sig, bus.Frame_Err, bus.Rx_Data);
    end
  endtask

  task automatic test_valid_frame(input logic [7:0] d);
    int sc;
    clear_mon();
    send_frame(d, 1'b1, sc);
    idle(20);
    exp_data = d;
    checks++;
    if (done_q.size() != 1 || err_cnt != 0) begin
      failures++;
      $display("[TB] FAIL valid_strobes got done=%0d err=%0d expected done=1 err=0", done_q.size(), err_cnt);
    end else begin
      checks++;
      if (done_q[0] !== d) begin
        failures++;
        $display("[TB] FAIL valid_data got=%h expected=%h", done_q[0], d);
      end
      checks++;
      if (done_cyc[0] - sc < 150 || done_cyc[0] - sc > 160) begin
        failures++;
        $display("[TB] FAIL valid_latency got=%0d expected=150..160", done_cyc[0] - sc);
      end
    end
  endtask

  task automatic test_frame_error();
    int sc;
    clear_mon();
    send_frame(8'h3C, 1'b0, sc);
    idle(20);
    checks++;
    if (err_cnt != 1 || done_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL frame_err_strobes got err=%0d done=%0d expected err=1 done=0", err_cnt, done_q.size());
    end
    checks++;
    if (bus.Rx_Data !== exp_data) begin
      failures++;
      $display("[TB] FAIL frame_err_hold got=%h expected=%h", bus.Rx_Data, exp_data);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      #1;
      bus.Rx_Pin_In = 1'b0;
      bus.H2L_Sig   = (k == 0);
      @(posedge clk);
    end
    idle(40);
    checks++;
    if (done_q.size() != 0 || err_cnt != 0) begin
      failures++;
      $display("[TB] FAIL glitch_no_strobe got done=%0d err=%0d expected 0/0", done_q.size(), err_cnt);
    end
    test_valid_frame(8'h5A);
  endtask

  task automatic test_back_to_back();
    int sc0, sc1;
    clear_mon();
    send_frame(8'h00, 1'b1, sc0);
    send_frame(8'hFF, 1'b1, sc1);
    idle(20);
    exp_data = 8'hFF;
    checks++;
    if (done_q.size() != 2 || err_cnt != 0) begin
      failures++;
      $display("[TB] FAIL b2b_count got done=%0d err=%0d expected done=2 err=0", done_q.size(), err_cnt);
    end else begin
      checks++;
      if (done_q[0] !== 8'h00 || done_q[1] !== 8'hFF) begin
        failures++;
        $display("[TB] FAIL b2b_data got=%h,%h expected=00,ff", done_q[0], done_q[1]);
      end
    end
  endtask

  task automatic test_rx_en_drop();
    int sc;
    clear_mon();
    fork
      send_frame(8'($urandom), 1'b1, sc);
      begin
        repeat (4 * BAUD + 8) @(posedge clk);
        #2;
        bus.Rx_En = 1'b0;
      end
    join
    idle(20);
    checks++;
    if (done_q.size() != 0 || err_cnt != 0 || bus.Rx_Data !== exp_data) begin
      failures++;
      $display("[TB] FAIL en_drop got done=%0d err=%0d data=%h expected 0/0/%h",
               done_q.size(), err_cnt, bus.Rx_Data, exp_data);
    end
    bus.Rx_En = 1'b1;
    idle(5);
    test_valid_frame(8'hC3);
  endtask

  task automatic test_reset_midframe();
    int sc;
    clear_mon();
    fork
      send_frame(8'($urandom), 1'b1, sc);
      begin
        repeat (6 * BAUD + 8) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.Rx_Data !== 8'h00 || bus.Rx_Done_Sig !== 1'b0 || bus.Frame_Err !== 1'b0) begin
          failures++;
          $display("[TB] FAIL midframe_reset got=%h/%b%b expected=00/00",
                   bus.Rx_Data, bus.Rx_Done_Sig, bus.Frame_Err);
        end
        @(posedge clk);
        #2;
        rstn = 1'b1;
      end
    join
    exp_data = 8'h00;
    idle(20);
    checks++;
    if (done_q.size() != 0 || err_cnt != 0) begin
      failures++;
      $display("[TB] FAIL reset_discard got done=%0d err=%0d expected 0/0", done_q.size(), err_cnt);
    end
    test_valid_frame(8'h81);
  endtask

  task automatic test_random_frames();
    int         sc, gap;
    logic [7:0] d;
    logic       stop;
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(3, 0) != 0);
      gap  = $urandom_range(5, 0);
      clear_mon();
      idle(gap);
      send_frame(d, stop, sc);
      idle(20);
      if (stop) exp_data = d;
      checks++;
      if (done_q.size() != (stop ? 1 : 0) || err_cnt != (stop ? 0 : 1)) begin
        failures++;
        $display("[TB] FAIL rand_strobes frame=%0d got done=%0d err=%0d expected done=%0d err=%0d",
                 n, done_q.size(), err_cnt, stop ? 1 : 0, stop ? 0 : 1);
      end
      checks++;
      if (bus.Rx_Data !== exp_data) begin
        failures++;
        $display("[TB] FAIL rand_data frame=%0d got=%h expected=%h", n, bus.Rx_Data, exp_data);
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("[TB] FAIL strobe_exclusive got=%0d expected=0", both_cnt);
    end
  endtask

  initial begin
    bus.Rx_Pin_In = 1'b1;
    bus.H2L_Sig   = 1'b0;
    bus.Rx_En     = 1'b1;
    test_reset();
    test_valid_frame(8'hA5);
    test_exclusive();
    test_frame_error();
    test_exclusive();
    test_glitch();
    test_back_to_back();
    test_exclusive();
    test_rx_en_drop();
    test_reset_midframe();
    test_random_frames();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
